// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Bit counter must index 0..width-1 and stays at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one result bit per clock, LSB first, borrow recirculated
// through a flop around a single full-subtractor cell.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_brw;
    logic [CntW-1:0]  r_cnt;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_d_next;

    full_sub_cell u_cell (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_bin  (r_brw),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // New diff bit enters at the MSB; written as shifts so WIDTH=1 needs no special case.
    assign w_d_next = (r_d_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_d_sr     <= '0;
            r_brw      <= 1'b0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a_in;
                        r_b_sr  <= b_in;
                        r_brw   <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_d_sr <= w_d_next;
                    r_brw  <= w_bout;
                    if (r_cnt == LastCnt) begin
                        diff_out   <= w_d_next;
                        borrow_out <= w_bout;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                S_FIN: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8, 4 and 1.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic       busy8, done8, brw8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, d4;
    logic       busy4, done4, brw4;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, d1;
    logic       busy1, done1, brw1;

    int n_checks = 0;
    int n_fail = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [1:0] q1[$];

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .diff_out(d8), .borrow_out(brw8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4),
        .busy(busy4), .done(done4), .diff_out(d4), .borrow_out(brw4)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .diff_out(d1), .borrow_out(brw1)
    );

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy8, done8, brw8, d8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_w8: got %h, want 0", {busy8, done8, brw8, d8});
        end
        n_checks++;
        if ({busy4, done4, brw4, d4} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_w4: got %h, want 0", {busy4, done4, brw4, d4});
        end
        n_checks++;
        if ({busy1, done1, brw1, d1} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_w1: got %h, want 0", {busy1, done1, brw1, d1});
        end
    endtask

    task automatic test_single_op(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] exp_d, input logic exp_b);
        int lat = 0;
        int nbusy = 0;
        logic [8:0] exp = 9'h1ff;
        @(negedge clk);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        q8.push_back({exp_b, exp_d});
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy8 && done8) begin
                n_fail++;
                $display("FAIL busy_done_overlap a=%0d b=%0d: got both high, want exclusive", a, b);
            end
            if (done8) lat = i;
            else if (busy8) nbusy++;
        end
        n_checks++;
        if (lat != 9) begin
            n_fail++;
            $display("FAIL done_latency a=%0d b=%0d: got %0d, want 9", a, b, lat);
        end
        n_checks++;
        if (nbusy != 8) begin
            n_fail++;
            $display("FAIL busy_cycles a=%0d b=%0d: got %0d, want 8", a, b, nbusy);
        end
        if (q8.size() > 0) exp = q8.pop_front();
        n_checks++;
        if ({brw8, d8} !== exp) begin
            n_fail++;
            $display("FAIL result a=%0d b=%0d: got borrow=%b diff=%h, want borrow=%b diff=%h",
                     a, b, brw8, d8, exp[8], exp[7:0]);
        end
        @(negedge clk);
        n_checks++;
        if (done8 !== 1'b0 || {brw8, d8} !== exp) begin
            n_fail++;
            $display("FAIL done_pulse_hold a=%0d b=%0d: got done=%b res=%h, want done=0 res=%h",
                     a, b, done8, {brw8, d8}, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av[3];
        logic [7:0] bv[3];
        logic [8:0] held;
        logic [8:0] exp;
        logic pbusy;
        int nacc = 0;
        int ndone = 0;
        int since = 0;
        av[0] = 8'd50;  bv[0] = 8'd20;
        av[1] = 8'd3;   bv[1] = 8'd7;
        av[2] = 8'd128; bv[2] = 8'd7;
        @(negedge clk);
        a8 = av[0];
        b8 = bv[0];
        start8 = 1'b1;
        pbusy = busy8;
        held = {brw8, d8};
        for (int c = 0; c < 100 && ndone < 3; c++) begin
            @(negedge clk);
            if (since > 0) since++;
            if (busy8 && !pbusy) begin
                q8.push_back({a8 < b8, 8'(a8 - b8)});
                since = 1;
                nacc++;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            if (done8) begin
                n_checks++;
                if (since != 9) begin
                    n_fail++;
                    $display("FAIL b2b_latency op=%0d: got %0d, want 9", ndone, since);
                end
                exp = (q8.size() > 0) ? q8.pop_front() : 9'h1ff;
                n_checks++;
                if ({brw8, d8} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_result op=%0d: got %h, want %h", ndone, {brw8, d8}, exp);
                end
                held = {brw8, d8};
                ndone++;
                if (ndone < 3) begin
                    a8 = av[ndone];
                    b8 = bv[ndone];
                end
            end else begin
                n_checks++;
                if ({brw8, d8} !== held) begin
                    n_fail++;
                    $display("FAIL b2b_hold: got %h, want %h", {brw8, d8}, held);
                end
            end
            pbusy = busy8;
        end
        start8 = 1'b0;
        n_checks++;
        if (ndone != 3 || nacc != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d done %0d accepted, want 3", ndone, nacc);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int nact = 0;
        @(negedge clk);
        a8 = 8'd17;
        b8 = 8'd3;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, brw8, d8} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, want 0", {busy8, done8, brw8, d8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 || busy8) nact++;
        end
        n_checks++;
        if (nact != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles, want 0", nact);
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [4:0] exp;
        int lat;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                @(negedge clk);
                a4 = 4'(ia);
                b4 = 4'(ib);
                start4 = 1'b1;
                q4.push_back({ia < ib, 4'(ia - ib)});
                @(posedge clk);
                #1;
                start4 = 1'b0;
                lat = 0;
                for (int i = 1; i <= 20 && lat == 0; i++) begin
                    @(negedge clk);
                    if (done4) lat = i;
                end
                n_checks++;
                if (lat != 5) begin
                    n_fail++;
                    $display("FAIL w4_latency a=%0d b=%0d: got %0d, want 5", ia, ib, lat);
                end
                exp = (q4.size() > 0) ? q4.pop_front() : 5'h1f;
                n_checks++;
                if ({brw4, d4} !== exp) begin
                    n_fail++;
                    $display("FAIL w4_result a=%0d b=%0d: got %h, want %h", ia, ib, {brw4, d4}, exp);
                end
            end
        end
    endtask

    task automatic test_exhaustive_w1();
        logic [1:0] exp;
        int lat;
        for (int ia = 0; ia < 2; ia++) begin
            for (int ib = 0; ib < 2; ib++) begin
                @(negedge clk);
                a1 = 1'(ia);
                b1 = 1'(ib);
                start1 = 1'b1;
                q1.push_back({ia < ib, 1'(ia - ib)});
                @(posedge clk);
                #1;
                start1 = 1'b0;
                lat = 0;
                for (int i = 1; i <= 20 && lat == 0; i++) begin
                    @(negedge clk);
                    if (done1) lat = i;
                end
                n_checks++;
                if (lat != 2) begin
                    n_fail++;
                    $display("FAIL w1_latency a=%0d b=%0d: got %0d, want 2", ia, ib, lat);
                end
                exp = (q1.size() > 0) ? q1.pop_front() : 2'b11;
                n_checks++;
                if ({brw1, d1} !== exp) begin
                    n_fail++;
                    $display("FAIL w1_result a=%0d b=%0d: got %b, want %b", ia, ib, {brw1, d1}, exp);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_op(8'd9, 8'd5, 8'h04, 1'b0);
        test_single_op(8'd5, 8'd9, 8'hFC, 1'b1);
        test_single_op(8'd0, 8'd1, 8'hFF, 1'b1);
        test_single_op(8'hFF, 8'hFF, 8'h00, 1'b0);
        test_single_op(8'd0, 8'hFF, 8'h01, 1'b1);
        test_back_to_back();
        test_reset_mid_run();
        test_single_op(8'd200, 8'd100, 8'd100, 1'b0);
        test_exhaustive_w4();
        test_exhaustive_w1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
